icache_responder: RTL and testbench

- Instruction-memory responder for the fetch stage. Serves `imemREN`/`imemaddr` requests and returns `imemload`, with `missed` high while the word is unavailable.
- Direct-mapped, one word per line. On a miss it performs a blocking refill from the backing RAM port.
- Sits between the fetch stage and the memory arbiter.
- Keeps saturating hit/miss counters for performance analysis.

---
 rtl/icache_responder_if.sv | 31 +++
 rtl/icache_responder.sv | 138 +++++++++++++
 tb/tb_icache_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side signal bundle for the instruction cache responder.
interface icache_responder_if #(
  parameter int unsigned RAM_ADDR_W = 32
);
  // fetch stage
  logic                  imemREN;
  logic [RAM_ADDR_W-1:0] imemaddr;
  logic [31:0]           imemload;
  logic                  missed;
  logic                  flush;
  // memory arbiter
  logic                  ramREN;
  logic [RAM_ADDR_W-1:0] ramaddr;
  logic [31:0]           ramload;
  logic                  ramwait;
  // performance counters
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;

  // cache side
  modport slave (
    input  imemREN, imemaddr, flush, ramload, ramwait,
    output imemload, missed, ramREN, ramaddr, hit_count, miss_count
  );

  // fetch stage / memory side
  modport master (
    output imemREN, imemaddr, flush, ramload, ramwait,
    input  imemload, missed, ramREN, ramaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache with blocking refill
// and saturating hit/miss counters.
module icache_responder #(
  parameter int unsigned SETS       = 16,
  parameter int unsigned RAM_ADDR_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  icache_responder_if.slave  bus
);

  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned TAG_W = RAM_ADDR_W - IDX - 2;
  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t                state_q, state_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic [RAM_ADDR_W-1:0] ramaddr_q, ramaddr_d;
  logic [IDX-1:0]        fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]      fill_tag_q, fill_tag_d;
  logic                  drop_q, drop_d;
  logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [31:0]           data_mem [SETS];

  logic [IDX-1:0]        req_idx_c;
  logic [TAG_W-1:0]      req_tag_c;
  logic                  hit_c;
  logic                  wr_en_c;

  // Lookup: hits are only served from IDLE and never while reset is asserted.
  always_comb begin
    req_idx_c = bus.imemaddr[IDX+1:2];
    req_tag_c = bus.imemaddr[RAM_ADDR_W-1:IDX+2];
    hit_c     = bus.imemREN & valid_q[req_idx_c] &
                (tag_mem[req_idx_c] == req_tag_c) &
                (state_q == IDLE) & ~RST;
  end

  // Fetch and refill outputs.
  always_comb begin
    bus.missed     = bus.imemREN & ~hit_c;
    bus.imemload   = hit_c ? data_mem[req_idx_c] : 32'd0;
    bus.ramREN     = (state_q == FILL);
    bus.ramaddr    = ramaddr_q;
    bus.hit_count  = hit_cnt_q;
    bus.miss_count = miss_cnt_q;
  end

  // Next-state: refill sequencing, valid bookkeeping and counters.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    ramaddr_d  = ramaddr_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    drop_d     = drop_q;
    wr_en_c    = 1'b0;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    if (hit_c && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.imemREN && !hit_c && !bus.flush) begin
          ramaddr_d  = {bus.imemaddr[RAM_ADDR_W-1:2], 2'b00};
          fill_idx_d = req_idx_c;
          fill_tag_d = req_tag_c;
          drop_d     = 1'b0;
          state_d    = FILL;
          if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
      end
      FILL: begin
        // A flush seen at any point of the fill drops the returning line.
        if (bus.flush) begin
          drop_d = 1'b1;
        end
        if (!bus.ramwait) begin
          wr_en_c             = 1'b1;
          valid_d[fill_idx_q] = ~(drop_q | bus.flush);
          state_d             = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.flush) begin
      valid_d = '0;
    end
  end

  // Control and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      ramaddr_q  <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      drop_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ramaddr_q  <= ramaddr_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
      drop_q     <= drop_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag/data arrays; contents are qualified by valid_q so they are not reset.
  always_ff @(posedge CLK) begin
    if (wr_en_c && !RST) begin
      tag_mem[fill_idx_q]  <= fill_tag_q;
      data_mem[fill_idx_q] <= bus.ramload;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: refill latency, aliasing, redirect,
// flush and reset behaviour with hand-computed expectations.
module tb_icache_responder;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   miss_cycles;

  icache_responder_if #(.RAM_ADDR_W(32)) bus ();

  icache_responder #(
    .SETS       (16),
    .RAM_ADDR_W (32)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (well before negedge).
  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Miss cycle plus one zero-wait fill cycle; returns at the first hit cycle.
  task automatic do_fill(input logic [31:0] addr, input logic [31:0] data);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.ramload  = data;
    bus.ramwait  = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.flush    = 1'b0;
    bus.ramload  = '0;
    bus.ramwait  = 1'b0;
    tick();

    // Request during reset: valid treated as 0, so it reports missed.
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    settle();
    check("rst_missed", 32'(bus.missed), 32'd1);
    tick();
    check("rst_ramren", 32'(bus.ramREN), 32'd0);
    rst         = 1'b0;
    bus.imemREN = 1'b0;
    settle();
    check("idle_missed", 32'(bus.missed), 32'd0);
    check("idle_load", bus.imemload, 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_hits", bus.hit_count, 32'd0);
    check("rst_misses", bus.miss_count, 32'd0);
    tick();

    // Cold miss, zero-wait refill.
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    bus.ramload  = 32'hDEAD_BEEF;
    bus.ramwait  = 1'b0;
    settle();
    check("cold_missed", 32'(bus.missed), 32'd1);
    check("cold_ramren0", 32'(bus.ramREN), 32'd0);
    tick();
    settle();
    check("cold_ramren1", 32'(bus.ramREN), 32'd1);
    check("cold_ramaddr", bus.ramaddr, 32'h40);
    check("cold_fill_missed", 32'(bus.missed), 32'd1);
    check("cold_misses", bus.miss_count, 32'd1);
    tick();
    settle();
    check("cold_hit_missed", 32'(bus.missed), 32'd0);
    check("cold_hit_load", bus.imemload, 32'hDEAD_BEEF);
    check("cold_ramren_off", 32'(bus.ramREN), 32'd0);
    check("hits_0", bus.hit_count, 32'd0);
    tick();
    settle();
    check("hits_1", bus.hit_count, 32'd1);
    tick();
    settle();
    check("hits_2", bus.hit_count, 32'd2);
    tick();

    // Three wait states on 0x100: missed for 5 cycles, then hit.
    bus.imemaddr = 32'h100;
    bus.ramload  = 32'h1111_2222;
    miss_cycles  = 0;
    settle();
    check("hits_3", bus.hit_count, 32'd3);
    for (int i = 0; i < 5; i++) begin
      bus.ramwait = (i == 4) ? 1'b0 : 1'b1;
      if (i > 0) settle();
      if (bus.missed) miss_cycles++;
      tick();
    end
    settle();
    check("wait_miss_cycles", 32'(miss_cycles), 32'd5);
    check("wait_hit_missed", 32'(bus.missed), 32'd0);
    check("wait_hit_load", bus.imemload, 32'h1111_2222);
    check("wait_misses", bus.miss_count, 32'd2);
    tick();
    bus.imemaddr = 32'h103;
    settle();
    check("byte_off_missed", 32'(bus.missed), 32'd0);
    check("byte_off_load", bus.imemload, 32'h1111_2222);
    tick();
    bus.imemREN = 1'b0;
    settle();
    check("noreq_missed", 32'(bus.missed), 32'd0);
    check("noreq_load", bus.imemload, 32'd0);
    tick();

    // Conflict: 0x0 and 0x40 share index 0.
    do_reset();
    do_fill(32'h0, 32'hA0A0_0000);
    settle();
    check("conf_a_load", bus.imemload, 32'hA0A0_0000);
    tick();
    do_fill(32'h40, 32'hB0B0_0040);
    settle();
    check("conf_b_load", bus.imemload, 32'hB0B0_0040);
    tick();
    bus.imemaddr = 32'h0;
    bus.ramload  = 32'hA0A0_0000;
    settle();
    check("conf_evicted", 32'(bus.missed), 32'd1);
    tick();
    tick();
    settle();
    check("conf_refill_load", bus.imemload, 32'hA0A0_0000);
    check("conf_misses", bus.miss_count, 32'd3);
    tick();

    // Redirect mid-fill: 0x204 (index 1) then 0x308 (index 2).
    bus.imemaddr = 32'h204;
    bus.ramload  = 32'hAAAA_0204;
    bus.ramwait  = 1'b1;
    settle();
    check("redir_miss", 32'(bus.missed), 32'd1);
    tick();
    bus.imemaddr = 32'h308;
    settle();
    check("redir_fill_missed", 32'(bus.missed), 32'd1);
    check("redir_ramaddr_held", bus.ramaddr, 32'h204);
    tick();
    bus.ramwait = 1'b0;
    settle();
    check("redir_done_missed", 32'(bus.missed), 32'd1);
    tick();
    bus.ramload = 32'hBBBB_0308;
    settle();
    check("redir_new_miss", 32'(bus.missed), 32'd1);
    check("redir_idle_ramren", 32'(bus.ramREN), 32'd0);
    tick();
    settle();
    check("redir_ramaddr_new", bus.ramaddr, 32'h308);
    tick();
    settle();
    check("redir_b_load", bus.imemload, 32'hBBBB_0308);
    tick();
    bus.imemaddr = 32'h204;
    settle();
    check("redir_a_missed", 32'(bus.missed), 32'd0);
    check("redir_a_load", bus.imemload, 32'hAAAA_0204);
    tick();

    // Flush in IDLE, then flush coinciding with a miss (no fill starts).
    do_fill(32'h80, 32'h8080_8080);
    settle();
    check("flush_pre_load", bus.imemload, 32'h8080_8080);
    tick();
    bus.flush = 1'b1;
    tick();
    settle();
    check("flush_idle_missed", 32'(bus.missed), 32'd1);
    tick();
    bus.flush   = 1'b0;
    bus.ramwait = 1'b1;
    settle();
    check("flush_miss_nofill", 32'(bus.ramREN), 32'd0);
    check("flush_miss_count", bus.miss_count, 32'd6);
    tick();
    settle();
    check("flush_fill_ramren", 32'(bus.ramREN), 32'd1);
    tick();
    // Flush in the same cycle the data returns: line is dropped.
    bus.ramwait = 1'b0;
    bus.flush   = 1'b1;
    tick();
    bus.flush = 1'b0;
    settle();
    check("flush_same_dropped", 32'(bus.missed), 32'd1);
    check("flush_same_ramren", 32'(bus.ramREN), 32'd0);
    tick();
    tick();
    settle();
    check("flush_refill_load", bus.imemload, 32'h8080_8080);
    tick();
    // Flush early in a fill, data returns later: line still dropped.
    bus.imemaddr = 32'h84;
    bus.ramload  = 32'h8484_8484;
    bus.ramwait  = 1'b1;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush   = 1'b0;
    bus.ramwait = 1'b0;
    tick();
    settle();
    check("flush_early_dropped", 32'(bus.missed), 32'd1);
    check("flush_early_misses", bus.miss_count, 32'd9);
    tick();
    tick();
    settle();
    check("flush_early_refill", bus.imemload, 32'h8484_8484);
    check("pre_rst_misses", bus.miss_count, 32'd10);
    tick();

    // Reset mid-fill abandons the refill and clears state.
    bus.imemaddr = 32'h88;
    bus.ramwait  = 1'b1;
    tick();
    settle();
    check("rstfill_ramren", 32'(bus.ramREN), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("rstfill_ramren_off", 32'(bus.ramREN), 32'd0);
    check("rstfill_hits", bus.hit_count, 32'd0);
    check("rstfill_misses", bus.miss_count, 32'd0);
    check("rstfill_ramaddr", bus.ramaddr, 32'd0);
    bus.imemaddr = 32'h84;
    settle();
    check("rstfill_line_gone", 32'(bus.missed), 32'd1);
    tick();
    bus.imemREN = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
